// File: rtl/accumulate_ctrl_if.sv
// Adder bus between the accumulate controller and the 16-bit ripple-carry adder.
// The controller is the master: it drives both operands and reads Sum/CO back.
interface accumulate_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] Add_A;
    logic [WIDTH-1:0] Add_B;
    logic [WIDTH-1:0] Add_Sum;
    logic             Add_CO;

    modport master (
        output Add_A,
        output Add_B,
        input  Add_Sum,
        input  Add_CO
    );

    modport slave (
        input  Add_A,
        input  Add_B,
        output Add_Sum,
        output Add_CO
    );
endinterface

// File: rtl/accumulate_ctrl.sv
// Accumulator control stage around an external combinational adder.
// Run and ClearA pass through one sample register. Acc/Done therefore appear
// SETTLE_CYCLES+3 edges after Run is first sampled high. One accumulate is
// done per press, and the FSM waits in HOLD until Run is released.
module accumulate_ctrl #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 2     // legal range 0..15
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Run,
    input  logic                      ClearA,
    input  logic [WIDTH-1:0]          Din,
    accumulate_ctrl_if.master         add_bus,
    output logic [WIDTH-1:0]          Acc,
    output logic                      CO,
    output logic                      Ovf,
    output logic                      Busy,
    output logic                      Done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] breg_q;
    logic             co_q;
    logic             ovf_q;
    logic             done_q;
    logic [3:0]       cnt_q;
    logic             run_q;
    logic             clr_q;

    // Control FSM with all datapath registers and registered Done.
    // NOTE: Reset is tested first inside the clocked block. This makes it synchronous and lets it override any state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
            state_q <= IDLE;
            acc_q   <= '0;
            breg_q  <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            run_q  <= Run;
            // A clear request counts only if it was sampled while idle, so
            // ClearA held through an operation is dropped rather than queued.
            clr_q  <= ClearA && (state_q == IDLE);
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (clr_q) begin
                        acc_q <= '0;
                        co_q  <= 1'b0;
                        ovf_q <= 1'b0;
                    end else if (run_q) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    breg_q  <= Din;
                    cnt_q   <= 4'(SETTLE_CYCLES);
                    state_q <= (SETTLE_CYCLES > 0) ? SETTLE : CAPTURE;
                end
                SETTLE: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    acc_q   <= add_bus.Add_Sum;
                    co_q    <= add_bus.Add_CO;
                    ovf_q   <= ovf_q | add_bus.Add_CO;
                    done_q  <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!run_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs come straight from registers or a state decode, so no input reaches an output combinationally.
    assign add_bus.Add_A = acc_q;
    assign add_bus.Add_B = breg_q;
    assign Acc           = acc_q;
    assign CO            = co_q;
    assign Ovf           = ovf_q;
    assign Done          = done_q;
    assign Busy          = (state_q == LOAD) || (state_q == SETTLE) || (state_q == CAPTURE);

endmodule

// File: tb/tb_accumulate_ctrl.sv
// Self-checking bench for accumulate_ctrl: a default build (SETTLE_CYCLES=2)
// and a SETTLE_CYCLES=0 build. Each has a behavioural adder on its bus.
module tb_accumulate_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, run, clear_a;
    logic [W-1:0] din, acc;
    logic         co, ovf, busy, done;

    logic         run0, clear0;
    logic [W-1:0] din0, acc0;
    logic         co0, ovf0, busy0, done0;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [W-1:0] acc;
        logic         co;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] acc_m;
    logic         ovf_m;

    always #5 clk = ~clk;

    accumulate_ctrl_if #(.WIDTH(W)) bus  ();
    accumulate_ctrl_if #(.WIDTH(W)) bus0 ();

    // Reference ripple-carry adders on each bus.
    assign {bus.Add_CO,  bus.Add_Sum}  = {1'b0, bus.Add_A}  + {1'b0, bus.Add_B};
    assign {bus0.Add_CO, bus0.Add_Sum} = {1'b0, bus0.Add_A} + {1'b0, bus0.Add_B};

    accumulate_ctrl #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
        .Clk(clk), .Reset(reset), .Run(run), .ClearA(clear_a), .Din(din),
        .add_bus(bus.master), .Acc(acc), .CO(co), .Ovf(ovf), .Busy(busy), .Done(done)
    );

    accumulate_ctrl #(.WIDTH(W), .SETTLE_CYCLES(0)) dut0 (
        .Clk(clk), .Reset(reset), .Run(run0), .ClearA(clear0), .Din(din0),
        .add_bus(bus0.master), .Acc(acc0), .CO(co0), .Ovf(ovf0), .Busy(busy0), .Done(done0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Queue the model result for one accumulate of d.
    task automatic push_model(input logic [W-1:0] d);
        logic [W:0] s;
        exp_t e;
        s      = {1'b0, acc_m} + {1'b0, d};
        acc_m  = s[W-1:0];
        ovf_m  = ovf_m | s[W];
        e.acc  = acc_m;
        e.co   = s[W];
        e.ovf  = ovf_m;
        sb.push_back(e);
    endtask

    // One press on the default unit. After the third edge (mid-SETTLE) Din is
    // changed to mid_din and ClearA is driven to mid_clr. Run stays high for
    // hold extra cycles after Done, and no second Done may appear.
    task automatic press(input string tag, input logic [W-1:0] d,
                         input logic [W-1:0] mid_din, input logic mid_clr, input int hold);
        int   n;
        int   extra;
        exp_t e;
        @(negedge clk);
        din = d;
        run = 1'b1;
        push_model(d);
        @(posedge clk);                  // edge k: Run sampled
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 3) begin
                din     = mid_din;
                clear_a = mid_clr;
            end
            if (done) break;
        end
        check({tag, " latency"}, n, 5);
        e = sb.pop_front();
        check({tag, " acc"}, acc, e.acc);
        check({tag, " co"},  co,  e.co);
        check({tag, " ovf"}, ovf, e.ovf);
        check({tag, " busy_with_done"}, busy, 0);
        clear_a = 1'b0;
        extra = 0;
        for (int i = 0; i < hold + 1; i++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check({tag, " single_done"}, extra, 0);
        @(negedge clk);
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({tag, " idle"}, busy, 0);
    endtask

    // Clear request in IDLE, optionally with Run high at the same time.
    task automatic clear_acc(input string tag, input logic with_run);
        int dn;
        @(negedge clk);
        clear_a = 1'b1;
        run     = with_run;
        @(negedge clk);
        clear_a = 1'b0;
        run     = 1'b0;
        acc_m   = '0;
        ovf_m   = 1'b0;
        dn      = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dn++;
        end
        check({tag, " acc"}, acc, 0);
        check({tag, " co"},  co,  0);
        check({tag, " ovf"}, ovf, 0);
        check({tag, " no_op"}, dn, 0);
    endtask

    initial begin
        int n, busy_cnt, dn;
        reset = 1'b1; run = 1'b0; clear_a = 1'b0; din = '0;
        run0  = 1'b0; clear0 = 1'b0; din0 = '0;
        acc_m = '0; ovf_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst acc",  acc,  0);
        check("rst co",   co,   0);
        check("rst ovf",  ovf,  0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst add_b", bus.Add_B, 0);
        @(negedge clk);
        reset = 1'b0;

        // Three increments by one.
        press("inc1", 16'h0001, 16'h0001, 1'b0, 0);
        press("inc2", 16'h0001, 16'h0001, 1'b0, 0);
        press("inc3", 16'h0001, 16'h0001, 1'b0, 0);
        check("add_a mirrors acc", bus.Add_A, 16'h0003);

        // Wrap-around with carry, then sticky Ovf.
        clear_acc("clr1", 1'b0);
        press("load_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 0);
        press("wrap",      16'h0001, 16'h0001, 1'b0, 0);
        press("after_wrap",16'h0002, 16'h0002, 1'b0, 0);

        // Run held for about 50 cycles gives a single accumulate.
        clear_acc("clr2", 1'b0);
        press("held",   16'h0010, 16'h0010, 1'b0, 45);
        press("repress",16'h0010, 16'h0010, 1'b0, 0);

        // ClearA during SETTLE is ignored.
        clear_acc("clr3", 1'b0);
        press("set1234", 16'h1234, 16'h1234, 1'b0, 0);
        press("clr_mid", 16'h0101, 16'h0101, 1'b1, 0);

        // ClearA and Run together in IDLE: the clear wins and no accumulate runs.
        clear_acc("clr_run", 1'b1);

        // Din changed during SETTLE: LOAD already captured the operand.
        press("din_mid", 16'h0042, 16'h7777, 1'b0, 0);

        // Reset during SETTLE with Acc=0x00AA.
        clear_acc("clr4", 1'b0);
        press("set00aa", 16'h00AA, 16'h00AA, 1'b0, 0);
        @(negedge clk);
        din = 16'h0005;
        run = 1'b1;
        @(posedge clk);                  // edge k
        repeat (3) @(posedge clk);       // now in SETTLE
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid acc",  acc,  0);
        check("rst_mid busy", busy, 0);
        check("rst_mid done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b0;
        acc_m = '0;
        ovf_m = 1'b0;
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dn++;
        end
        check("rst_mid quiet", dn, 0);
        check("rst_mid acc_after", acc, 0);

        // SETTLE_CYCLES=0 build.
        @(negedge clk);
        din0 = 16'h0003;
        run0 = 1'b1;
        @(posedge clk);                  // edge k
        n = 0;
        busy_cnt = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (busy0) busy_cnt++;
            if (done0) break;
        end
        check("s0 latency", n, 3);
        check("s0 acc",     acc0, 16'h0003);
        check("s0 co",      co0, 0);
        check("s0 busy_cycles", busy_cnt, 2);
        @(negedge clk);
        run0 = 1'b0;
        repeat (3) @(posedge clk);

        check("scoreboard empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Stop a hung run with a failure report.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/accumulate_ctrl.md
Name: accumulate_ctrl

Overview:
- Sequential control and register stage wrapped around the 16-bit combinational ripple-carry adder.
- Holds the accumulator register and drives it onto the adder A input; captures a switch operand and drives it onto the adder B input.
- Waits a fixed number of cycles for carry propagation, then writes the adder result back into the accumulator.
- Performs exactly one accumulate per Run press; supports clearing the accumulator.

Parameters:
- WIDTH, 16, datapath width of operands, accumulator and adder interface.
- SETTLE_CYCLES, 2, cycles allowed for adder propagation between operand load and result capture; legal range 0..15.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  level request; one accumulate per low-to-high press, synchronous to Clk.
- ClearA  input  1  clears accumulator, CO and Ovf; honoured only in IDLE.
- Din  input  WIDTH  operand source, from switches.
- Add_A  output  WIDTH  to adder A; equals Acc.
- Add_B  output  WIDTH  to adder B; equals internal operand register Breg.
- Add_Sum  input  WIDTH  from adder Sum.
- Add_CO  input  1  from adder CO.
- Acc  output  WIDTH  accumulator value.
- CO  output  1  carry-out of the most recent accumulate.
- Ovf  output  1  sticky: set by any accumulate with carry-out.
- Busy  output  1  high in LOAD, SETTLE and CAPTURE.
- Done  output  1  one-cycle pulse when the new Acc first becomes visible.

Behaviour:
Reset and clocking:
- One clock; reset is synchronous and active-high.
- On Reset sampled high: state=IDLE, Acc=0, Breg=0, CO=0, Ovf=0, Busy=0, Done=0, settle counter=0.
- Reset overrides every other input in every state, including mid-operation; no capture occurs.

Combinational outputs:
- Add_A=Acc and Add_B=Breg, purely from registers (no input-to-output paths).
- Busy is decoded from state.

State machine (states IDLE, LOAD, SETTLE, CAPTURE, HOLD):
- IDLE:
  - ClearA=1 → Acc, CO, Ovf <= 0; stay IDLE. ClearA has priority over Run.
  - Else Run=1 → LOAD.
  - Else stay IDLE.
- LOAD:
  - Breg <= Din; counter <= SETTLE_CYCLES.
  - Next state is SETTLE if SETTLE_CYCLES>0, else CAPTURE.
- SETTLE:
  - Counter decrements each cycle.
  - Leave for CAPTURE in the cycle counter==1, giving exactly SETTLE_CYCLES cycles in SETTLE.
- CAPTURE:
  - Acc <= Add_Sum; CO <= Add_CO; Ovf <= Ovf | Add_CO; Done <= 1.
  - Next state HOLD.
- HOLD:
  - Done <= 0 after its single cycle.
  - Stay until Run=0, then IDLE. A held Run never triggers a second accumulate.

Latency and data rules:
- Run sampled high at edge k (in IDLE) → Acc and Done visible after edge k+3+SETTLE_CYCLES; 5 cycles at default.
- Din is sampled only at the LOAD edge. Changes to Din during SETTLE, CAPTURE or HOLD have no effect.
- ClearA outside IDLE is ignored, not queued.
- Arithmetic is modulo 2^WIDTH; wrap-around is legal. CO reflects only the last accumulate; Ovf is cleared only by ClearA or Reset.
- Done and Busy are never high together.

Test Plan:
- Reset, then Din=0x0001 and three Run presses → Acc=0x0001, 0x0002, 0x0003; CO=0; Ovf=0; each Done exactly one cycle, 5 cycles after Run sampled.
- Acc=0xFFFF (via Din=0xFFFF after clear), then Din=0x0001 and Run → Acc=0x0000, CO=1, Ovf=1. Next Din=0x0002 and Run → Acc=0x0002, CO=0, Ovf stays 1.
- Run held high for 50 cycles with Din=0x0010 from Acc=0 → exactly one accumulate (Acc=0x0010, one Done pulse). Release and press again → Acc=0x0020.
- Acc=0x1234, ClearA asserted during SETTLE → ignored, Acc=0x1234+Din. ClearA and Run both high in IDLE → Acc=0, CO=0, Ovf=0, no accumulate.
- Reset asserted during SETTLE with Acc=0x00AA → next cycle Acc=0, Busy=0, state IDLE, no Done pulse. Din changed mid-SETTLE in a normal run → result uses the Din value captured at LOAD.
- SETTLE_CYCLES=0 build: Din=0x0003 from Acc=0 → Acc=0x0003 and Done after edge k+3; Busy high for exactly 2 cycles.
